dcache: RTL and testbench
=========================

Name: dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the pipeline memory stage and the RAM/bus arbiter.
- Answers the memory stage's dmemREN/dmemWEN/dmemaddr/dmemstore requests with dhit/dmemload.
- On a miss it issues word-wide RAM transactions. On halt it writes back every dirty line, then asserts flushed.

Parameters:
- SETS, 8, number of lines; power of two, at least 2. IDX_W = log2(SETS).
- Block size is fixed at 2 words. TAG_W = 32 - IDX_W - 3.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dmemREN  in  1  memory-stage read request.
- dmemWEN  in  1  memory-stage write request.
- dmemaddr  in  32  byte address. Tag [31:IDX_W+3], index [IDX_W+2:3], block offset [2]; bits [1:0] ignored.
- dmemstore  in  32  write data.
- halt  in  1  start flush; level, sampled in IDLE.
- dhit  out  1  request satisfied this cycle.
- dmemload  out  32  read data, valid when dhit.
- flushed  out  1  flush complete, sticky until reset.
- dREN  out  1  RAM read.
- dWEN  out  1  RAM write.
- daddr  out  32  RAM word address, bits [1:0] = 0.
- dstore  out  32  RAM write data.
- dwait  in  1  RAM busy; a transaction completes on a cycle with dwait=0.
- dload  in  32  RAM read data, valid when dwait=0.

Behaviour:
- Storage per set: valid, dirty, tag[TAG_W], data[2][32].
- Reset (asynchronous, immediate, no clock needed):
  - All valid/dirty bits cleared; state = IDLE; flush index = 0.
  - dhit, flushed, dREN, dWEN = 0; daddr, dstore, dmemload = 0.
  - An in-flight RAM transaction is dropped; dREN/dWEN fall asynchronously.
- Request priority: WEN has priority when REN and WEN are both high. Halt in IDLE has priority over any request.
- IDLE, hit (valid && tag match), combinational, same cycle:
  - dhit = 1.
  - Read: dmemload = data[idx][off].
  - Write: at the clock edge, data[idx][off] <= dmemstore and dirty <= 1.
- IDLE, miss:
  - Victim valid and dirty -> WB0; otherwise -> LD0.
  - dhit = 0.
- WB0: dWEN=1, daddr={victim tag, idx, 3'b000}, dstore=word0; on !dwait -> WB1.
- WB1: dWEN=1, daddr=+4, dstore=word1; on !dwait -> LD0.
- LD0: dREN=1, daddr={req tag, idx, 3'b000}; on !dwait latch dload into word0 -> LD1.
- LD1: dREN=1, daddr=+4; on !dwait latch word1 and set valid=1, dirty=0, tag=req tag -> IDLE.
- After a miss: the request is re-looked up the cycle after returning to IDLE and hits then. Write-miss data is applied on that hit. Miss latency with dwait=0 is 3 cycles clean, 5 dirty.
- Outside IDLE:
  - dhit = 0.
  - Request inputs are ignored except tag/idx, which must be held stable by the pipeline (freeze); the cache latches nothing from them.
- Stall behaviour: while dwait=1, state, daddr, dstore and the strobes hold unchanged.
- Only one of dREN/dWEN is ever high.
- FLUSH (entered from IDLE when halt=1):
  - Walk index 0..SETS-1.
  - Dirty valid line: FWB0 then FWB1, same as WB0/WB1 using the stored tag; then clear dirty and increment the index.
  - Clean line: skip in 1 cycle.
  - After index SETS-1 -> DONE.
- DONE: flushed=1, all RAM strobes 0, dhit=0. Remains until reset; halt deassertion has no effect.
- Halt raised during a miss: the miss completes first, then the cache enters FLUSH from IDLE.

Test Plan:
- Cold read 0x00000040, RAM dwait=0, dload 0xDEADBEEF then 0xCAFEF00D:
  - dREN @0x40 then @0x44.
  - dhit=1 on 4th cycle, dmemload=0xDEADBEEF.
  - Read 0x44 -> same-cycle dhit, dmemload=0xCAFEF00D.
- Write hit 0x40 <= 0x11112222, then read 0x80 (same index 0, new tag):
  - dWEN @0x40 data 0x11112222.
  - dWEN @0x44 data 0xCAFEF00D.
  - dREN @0x80, @0x84.
  - Then hit.
- dwait held high 5 cycles in LD0:
  - daddr stays 0x80, dREN stays 1, dhit stays 0.
  - Completion occurs on the first dwait=0 cycle.
- Write miss 0x100 <= 0xA5A5A5A5, clean victim:
  - dREN @0x100, @0x104.
  - Then dhit; a later read 0x100 returns 0xA5A5A5A5.
- Dirty lines at index 0 (tag of 0x40) and 5 (address 0x68), then halt=1:
  - Exactly 4 dWEN in order 0x40, 0x44, 0x68, 0x6C.
  - flushed=1 and held; a subsequent dmemREN gets dhit=0.
- nRST pulsed low mid-LD1 between clock edges:
  - dREN=0 immediately.
  - After release, read 0x40 misses again (valid cleared).

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with 2-word blocks.
// Hits are answered combinationally in IDLE. Misses refill over a word-wide RAM port,
// writing back a dirty victim first. Halt walks every set, writes back dirty lines,
// then parks in DONE with flushed asserted.
module dcache #(
  parameter int unsigned SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 3;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] WB0   = 4'd1;
  localparam logic [3:0] WB1   = 4'd2;
  localparam logic [3:0] LD0   = 4'd3;
  localparam logic [3:0] LD1   = 4'd4;
  localparam logic [3:0] FLUSH = 4'd5;
  localparam logic [3:0] FWB0  = 4'd6;
  localparam logic [3:0] FWB1  = 4'd7;
  localparam logic [3:0] DONE  = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS][2];
  logic [31:0]      data_d [SETS][2];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_off;
  logic             req;
  logic             hit;
  logic             flush_last;
  logic             unused_addr;

  // The pipeline holds the address stable during a miss, so it is used directly.
  assign req_tag     = dmemaddr[31:IDX_W+3];
  assign req_idx     = dmemaddr[IDX_W+2:3];
  assign req_off     = dmemaddr[2];
  assign req         = dmemREN | dmemWEN;
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign flush_last  = (fidx_q == IDX_W'(SETS - 1));
  assign unused_addr = ^dmemaddr[1:0];

  // Next-state, array updates and all outputs.
  always_comb begin
    state_d  = state_q;
    fidx_d   = fidx_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    data_d   = data_q;
    dhit     = 1'b0;
    dmemload = 32'h0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSH;
        end else if (req) begin
          if (hit) begin
            dhit = 1'b1;
            if (dmemWEN) begin
              data_d[req_idx][req_off] = dmemstore;
              dirty_d[req_idx]         = 1'b1;
            end else begin
              dmemload = data_q[req_idx][req_off];
            end
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WB0;
          end else begin
            state_d = LD0;
          end
        end
      end
      WB0: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 3'b000};
        dstore = data_q[req_idx][0];
        if (!dwait) state_d = WB1;
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 3'b100};
        dstore = data_q[req_idx][1];
        if (!dwait) state_d = LD0;
      end
      LD0: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 3'b000};
        if (!dwait) begin
          data_d[req_idx][0] = dload;
          state_d            = LD1;
        end
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, 3'b100};
        if (!dwait) begin
          data_d[req_idx][1] = dload;
          valid_d[req_idx]   = 1'b1;
          dirty_d[req_idx]   = 1'b0;
          tag_d[req_idx]     = req_tag;
          state_d            = IDLE;
        end
      end
      FLUSH: begin
        if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
          state_d = FWB0;
        end else if (flush_last) begin
          state_d = DONE;
        end else begin
          fidx_d = fidx_q + IDX_W'(1);
        end
      end
      FWB0: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[fidx_q], fidx_q, 3'b000};
        dstore = data_q[fidx_q][0];
        if (!dwait) state_d = FWB1;
      end
      FWB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[fidx_q], fidx_q, 3'b100};
        dstore = data_q[fidx_q][1];
        if (!dwait) begin
          dirty_d[fidx_q] = 1'b0;
          if (flush_last) begin
            state_d = DONE;
          end else begin
            fidx_d  = fidx_q + IDX_W'(1);
            state_d = FLUSH;
          end
        end
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and line status, cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      fidx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage; contents are qualified by valid, so no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, stall/flush/reset sequences,
// and randomized traffic checked against a flat-memory reference with a residency model.
module tb_dcache;

  localparam int unsigned SETS = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN, halt, dwait;
  logic [31:0] dmemaddr, dmemstore, dload;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;

  dcache #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int both_cnt = 0;
  logic stall_en;

  // RAM behind the cache and the transactions it completed.
  typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } tx_t;
  tx_t         txq [$];
  logic [31:0] ram [1024];

  assign dload = ram[daddr[11:2]];

  // Record completed RAM transactions and commit writes.
  always @(posedge CLK) begin
    if (dREN && dWEN) both_cnt <= both_cnt + 1;
    if ((dREN || dWEN) && !dwait) begin
      txq.push_back({dWEN, daddr, dstore});
      if (dWEN) ram[daddr[11:2]] <= dstore;
    end
  end

  // Reference: flat memory plus which block each set holds.
  logic [31:0] mem_ref [1024];
  logic        ref_v [SETS];
  logic        ref_d [SETS];
  logic [31:0] ref_blk [SETS];

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      ref_v[s] = 1'b0;
      ref_d[s] = 1'b0;
      ref_blk[s] = 32'h0;
    end
  endfunction

  // Returns the extra cycles before dhit with dwait=0 and the value a read sees.
  function automatic int model_access(input logic w, input logic [31:0] a,
                                      input logic [31:0] d, output logic [31:0] rd);
    int s;
    int cost;
    logic [31:0] blk;
    blk = a >> 3;
    s = int'(blk % SETS);
    if (ref_v[s] && ref_blk[s] == blk) begin
      cost = 0;
    end else begin
      cost = (ref_v[s] && ref_d[s]) ? 5 : 3;
      ref_v[s] = 1'b1;
      ref_d[s] = 1'b0;
      ref_blk[s] = blk;
    end
    if (w) begin
      mem_ref[a[11:2]] = d;
      ref_d[s] = 1'b1;
    end
    rd = mem_ref[a[11:2]];
    return cost;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge and hold it until dhit (bounded).
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rd, output logic hit);
    dmemREN = r;
    dmemWEN = w;
    dmemaddr = a;
    dmemstore = d;
    cyc = 0;
    if (stall_en) dwait = ($urandom_range(0, 3) == 0);
    #1;
    while (!dhit && cyc < 200) begin
      @(negedge CLK);
      if (stall_en) dwait = ($urandom_range(0, 3) == 0);
      #1;
      cyc++;
    end
    hit = dhit;
    rd = dmemload;
    @(negedge CLK);
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    dwait = 1'b0;
  endtask

  task automatic wait_flushed(input string name);
    int n;
    n = 0;
    #1;
    while (!flushed && n < 500) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check(name, {31'b0, flushed}, 32'h1);
  endtask

  typedef struct {
    logic ren; logic wen; logic [31:0] addr; logic [31:0] wdata;
    int cyc; logic [31:0] rdata; int ntx;
    logic [3:0] txw; logic [3:0][31:0] txa; logic [3:0][31:0] txd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int c, input logic [31:0] rd,
                              input int n, input logic [3:0] tw, input logic [127:0] ta,
                              input logic [127:0] td);
    vec_t v;
    v.ren = r; v.wen = w; v.addr = a; v.wdata = d; v.cyc = c; v.rdata = rd;
    v.ntx = n; v.txw = tw; v.txa = ta; v.txd = td;
    return v;
  endfunction

  initial begin
    vec_t        vec [9];
    int          cyc, n, cost, mis;
    logic [31:0] rd, exp_rd, a;
    logic        hit;
    int          op;
    tx_t         expq [$];

    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'h0; dmemstore = 32'h0;
    halt = 1'b0; dwait = 1'b0; stall_en = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] <= 32'h3000_0000 + 32'(i);
      mem_ref[i] = 32'h3000_0000 + 32'(i);
    end
    ram[16] <= 32'hDEAD_BEEF; mem_ref[16] = 32'hDEAD_BEEF;
    ram[17] <= 32'hCAFE_F00D; mem_ref[17] = 32'hCAFE_F00D;
    model_reset();

    // Reset state
    #2;
    check("rst_dhit", {31'b0, dhit}, 32'h0);
    check("rst_flushed", {31'b0, flushed}, 32'h0);
    check("rst_strobes", {30'b0, dREN, dWEN}, 32'h0);
    check("rst_daddr", daddr, 32'h0);
    check("rst_dstore", dstore, 32'h0);
    check("rst_dmemload", dmemload, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Directed vectors, dwait=0
    vec[0] = mk(1, 0, 32'h40, 0, 3, 32'hDEADBEEF, 2, 4'b0000, {32'h0, 32'h0, 32'h44, 32'h40}, 0);
    vec[1] = mk(1, 0, 32'h44, 0, 0, 32'hCAFEF00D, 0, 4'b0000, 0, 0);
    vec[2] = mk(0, 1, 32'h40, 32'h11112222, 0, 0, 0, 4'b0000, 0, 0);
    vec[3] = mk(1, 0, 32'h80, 0, 5, 32'h30000020, 4, 4'b0011,
                {32'h84, 32'h80, 32'h44, 32'h40}, {32'h0, 32'h0, 32'hCAFEF00D, 32'h11112222});
    vec[4] = mk(0, 1, 32'h100, 32'hA5A5A5A5, 3, 0, 2, 4'b0000,
                {32'h0, 32'h0, 32'h104, 32'h100}, 0);
    vec[5] = mk(1, 0, 32'h100, 0, 0, 32'hA5A5A5A5, 0, 4'b0000, 0, 0);
    vec[6] = mk(1, 0, 32'h104, 0, 0, 32'h30000041, 0, 4'b0000, 0, 0);
    vec[7] = mk(1, 1, 32'h104, 32'h00000077, 0, 0, 0, 4'b0000, 0, 0);
    vec[8] = mk(1, 0, 32'h104, 0, 0, 32'h00000077, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 9; i++) begin
      txq.delete();
      do_req(vec[i].ren, vec[i].wen, vec[i].addr, vec[i].wdata, cyc, rd, hit);
      cost = model_access(vec[i].wen, vec[i].addr, vec[i].wdata, exp_rd);
      check($sformatf("v%0d_hit", i), {31'b0, hit}, 32'h1);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vec[i].cyc));
      if (!vec[i].wen) check($sformatf("v%0d_rdata", i), rd, vec[i].rdata);
      check($sformatf("v%0d_ntx", i), 32'(txq.size()), 32'(vec[i].ntx));
      for (int j = 0; j < vec[i].ntx; j++) begin
        if (j < txq.size()) begin
          check($sformatf("v%0d_tx%0d_addr", i, j), txq[j].a, vec[i].txa[j]);
          check($sformatf("v%0d_tx%0d_we", i, j), {31'b0, txq[j].we}, {31'b0, vec[i].txw[j]});
          if (vec[i].txw[j]) check($sformatf("v%0d_tx%0d_data", i, j), txq[j].d, vec[i].txd[j]);
        end
      end
    end

    // dwait held high for 5 cycles in LD0 (dirty victim 0x100 written back first)
    txq.delete();
    dmemREN = 1'b1; dmemaddr = 32'h80; dwait = 1'b0;
    n = 0;
    #1;
    while (!(dREN && daddr == 32'h80) && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    check("stall_reach_ld0", {31'b0, dREN}, 32'h1);
    dwait = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      check($sformatf("stall%0d_dren", k), {31'b0, dREN}, 32'h1);
      check($sformatf("stall%0d_daddr", k), daddr, 32'h80);
      check($sformatf("stall%0d_dhit", k), {31'b0, dhit}, 32'h0);
    end
    dwait = 1'b0;
    @(negedge CLK); #1;
    check("stall_release_daddr", daddr, 32'h84);
    n = 0;
    while (!dhit && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    cost = model_access(1'b0, 32'h80, 32'h0, exp_rd);
    check("stall_hit", {31'b0, dhit}, 32'h1);
    check("stall_rdata", dmemload, exp_rd);
    check("stall_ntx", 32'(txq.size()), 32'd4);
    if (txq.size() == 4) begin
      check("stall_wb0", txq[0].a, 32'h100);
      check("stall_wb1_data", txq[1].d, 32'h77);
      check("stall_ld0", txq[2].a, 32'h80);
    end
    @(negedge CLK);
    dmemREN = 1'b0;

    // Randomized traffic, no stalls then random stalls
    for (int pass = 0; pass < 2; pass++) begin
      stall_en = (pass == 1);
      for (int i = 0; i < 250; i++) begin
        a = 32'($urandom_range(0, 127)) << 2;
        op = int'($urandom_range(0, 3));
        dmemstore = $urandom;
        cost = model_access(op >= 2, a, dmemstore, exp_rd);
        do_req(op != 2, op >= 2, a, dmemstore, cyc, rd, hit);
        check($sformatf("rnd%0d_%0d_hit", pass, i), {31'b0, hit}, 32'h1);
        if (!stall_en) check($sformatf("rnd%0d_%0d_cycles", pass, i), 32'(cyc), 32'(cost));
        if (op < 2) check($sformatf("rnd%0d_%0d_rdata", pass, i), rd, exp_rd);
      end
    end
    stall_en = 1'b0;

    // Full flush: dirty lines written back in index order, RAM matches reference after
    expq.delete();
    for (int s = 0; s < SETS; s++) begin
      if (ref_v[s] && ref_d[s]) begin
        expq.push_back({1'b1, ref_blk[s] << 3, mem_ref[ref_blk[s][8:0] << 1]});
        expq.push_back({1'b1, (ref_blk[s] << 3) + 32'h4, mem_ref[(ref_blk[s][8:0] << 1) + 10'd1]});
      end
    end
    txq.delete();
    halt = 1'b1;
    wait_flushed("flush_done");
    check("flush_ntx", 32'(txq.size()), 32'(expq.size()));
    for (int j = 0; j < expq.size(); j++) begin
      if (j < txq.size()) begin
        check($sformatf("flush_tx%0d_addr", j), txq[j].a, expq[j].a);
        check($sformatf("flush_tx%0d_data", j), txq[j].d, expq[j].d);
        check($sformatf("flush_tx%0d_we", j), {31'b0, txq[j].we}, 32'h1);
      end
    end
    @(negedge CLK);
    mis = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== mem_ref[i]) mis++;
    check("flush_ram_image", 32'(mis), 32'h0);
    halt = 1'b0;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      check($sformatf("done%0d_flushed", k), {31'b0, flushed}, 32'h1);
      check($sformatf("done%0d_dhit", k), {31'b0, dhit}, 32'h0);
      check($sformatf("done%0d_strobes", k), {30'b0, dREN, dWEN}, 32'h0);
    end
    dmemREN = 1'b0;

    // Reset pulsed low mid-LD1, between clock edges
    @(negedge CLK);
    nRST = 1'b0; #2; nRST = 1'b1;
    model_reset();
    @(negedge CLK);
    check("rst2_flushed", {31'b0, flushed}, 32'h0);
    dmemREN = 1'b1; dmemaddr = 32'h40; dwait = 1'b0;
    n = 0;
    #1;
    while (!(dREN && daddr == 32'h44) && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    check("rst_reach_ld1", daddr, 32'h44);
    dwait = 1'b1;
    #1;
    nRST = 1'b0;
    #1;
    check("rst_async_dren", {31'b0, dREN}, 32'h0);
    check("rst_async_daddr", daddr, 32'h0);
    #1;
    nRST = 1'b1;
    dwait = 1'b0;
    dmemREN = 1'b0;
    @(negedge CLK);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd, hit);
    cost = model_access(1'b0, 32'h40, 32'h0, exp_rd);
    check("post_rst_cycles", 32'(cyc), 32'd3);
    check("post_rst_rdata", rd, exp_rd);

    // Dirty lines at sets 0 and 5, then halt: exactly four writes in order
    do_req(1'b0, 1'b1, 32'h40, 32'hAAAA0001, cyc, rd, hit);
    check("fl2_w40_cycles", 32'(cyc), 32'd0);
    do_req(1'b0, 1'b1, 32'h68, 32'hBBBB0002, cyc, rd, hit);
    check("fl2_w68_cycles", 32'(cyc), 32'd3);
    txq.delete();
    halt = 1'b1;
    wait_flushed("fl2_done");
    check("fl2_ntx", 32'(txq.size()), 32'd4);
    if (txq.size() == 4) begin
      check("fl2_a0", txq[0].a, 32'h40);
      check("fl2_a1", txq[1].a, 32'h44);
      check("fl2_a2", txq[2].a, 32'h68);
      check("fl2_a3", txq[3].a, 32'h6C);
      check("fl2_d0", txq[0].d, 32'hAAAA0001);
      check("fl2_d2", txq[2].d, 32'hBBBB0002);
      check("fl2_we", {28'b0, txq[0].we, txq[1].we, txq[2].we, txq[3].we}, 32'hF);
    end
    halt = 1'b0;

    check("never_both_strobes", 32'(both_cnt), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
